enemy_wave_ctrl: RTL and testbench

//   Scheduler for the enemy-plane slots of the shooter. Owns N_SLOTS enemy records
//   (state, x, y, health): spawns enemies on a frame-based timer into free slots,

---
 rtl/enemy_wave_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_enemy_wave_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_wave_ctrl.sv
// Enemy-plane slot scheduler: timed spawns into free slots, downward motion,
// hit/health handling, explosion window and kill counting.
module enemy_wave_ctrl #(
  parameter int         N_SLOTS      = 4,
  parameter int         SPAWN_FRAMES = 90,
  parameter int         FALL_STEP    = 2,
  parameter int         Y_LIMIT      = 480,
  parameter int         INIT_HEALTH  = 3,
  parameter int         BOOM_FRAMES  = 16,
  parameter int         X_MAX        = 590,
  parameter logic [9:0] LFSR_SEED    = 10'h2A5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic                   game_en,
  input  logic [N_SLOTS-1:0]     hit,
  output logic [N_SLOTS-1:0]     slot_en,
  output logic [N_SLOTS-1:0]     slot_boom,
  output logic [10*N_SLOTS-1:0]  slot_x,
  output logic [10*N_SLOTS-1:0]  slot_y,
  output logic [3*N_SLOTS-1:0]   slot_health,
  output logic                   spawn_pulse,
  output logic                   escape_pulse,
  output logic [7:0]             kills
);

  localparam int SW = $clog2(SPAWN_FRAMES + 1);
  localparam int BW = $clog2(BOOM_FRAMES + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BOOM   = 2'd2
  } slot_state_t;

  slot_state_t     state_r    [N_SLOTS];
  slot_state_t     state_s    [N_SLOTS];
  logic [9:0]      x_r        [N_SLOTS];
  logic [9:0]      x_s        [N_SLOTS];
  logic [9:0]      y_r        [N_SLOTS];
  logic [9:0]      y_s        [N_SLOTS];
  logic [2:0]      health_r   [N_SLOTS];
  logic [2:0]      health_s   [N_SLOTS];
  logic [BW-1:0]   boom_cnt_r [N_SLOTS];
  logic [BW-1:0]   boom_cnt_s [N_SLOTS];

  logic [SW-1:0]   spawn_cnt_r, spawn_cnt_s;
  logic [9:0]      lfsr_r, lfsr_s, spawn_x_s;
  logic            spawn_try_s, spawn_found_s;
  logic [2:0]      spawn_idx_s;
  logic [3:0]      kill_cnt_s;
  logic [8:0]      kills_sum_s;
  logic [7:0]      kills_r, kills_s;
  logic            escape_s;
  logic [10:0]     y_sum_s;

  logic [N_SLOTS-1:0] slot_en_r, slot_boom_r;
  logic               spawn_pulse_r, escape_pulse_r;

  // Random source, spawn timer and lowest-index free-slot search
  always_comb begin
    lfsr_s        = {lfsr_r[8:0], lfsr_r[9] ^ lfsr_r[6]};
    spawn_x_s     = (lfsr_r <= 10'(X_MAX)) ? lfsr_r : (lfsr_r - 10'(X_MAX + 1));
    spawn_try_s   = 1'b0;
    spawn_cnt_s   = spawn_cnt_r;
    spawn_found_s = 1'b0;
    spawn_idx_s   = 3'd0;
    if (game_en && frame_tick) begin
      if (spawn_cnt_r == SW'(SPAWN_FRAMES - 1)) begin
        spawn_cnt_s = '0;
        spawn_try_s = 1'b1;
      end else begin
        spawn_cnt_s = spawn_cnt_r + SW'(1);
      end
    end else begin
      spawn_cnt_s = spawn_cnt_r;
    end
    // Only slots idle before this edge qualify, so a slot freed now waits a turn
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (state_r[i] == ST_IDLE) begin
        spawn_found_s = 1'b1;
        spawn_idx_s   = 3'(i);
      end else begin
        spawn_found_s = spawn_found_s;
      end
    end
  end

  // Per-slot next state: hits, fall, escape, explosion window, spawn commit
  always_comb begin
    kill_cnt_s = 4'd0;
    escape_s   = 1'b0;
    y_sum_s    = 11'd0;
    for (int i = 0; i < N_SLOTS; i++) begin
      state_s[i]    = state_r[i];
      x_s[i]        = x_r[i];
      y_s[i]        = y_r[i];
      health_s[i]   = health_r[i];
      boom_cnt_s[i] = boom_cnt_r[i];
      case (state_r[i])
        ST_IDLE: begin
          if (spawn_try_s && spawn_found_s && (spawn_idx_s == 3'(i))) begin
            state_s[i]  = ST_ACTIVE;
            x_s[i]      = spawn_x_s;
            y_s[i]      = 10'd0;
            health_s[i] = 3'(INIT_HEALTH);
          end else begin
            state_s[i] = ST_IDLE;
          end
        end
        ST_ACTIVE: begin
          if (!game_en) begin
            state_s[i] = ST_ACTIVE;
          end else if (hit[i] && (health_r[i] == 3'd1)) begin
            // Killing hit wins over motion on the same frame
            state_s[i]    = ST_BOOM;
            health_s[i]   = 3'd0;
            boom_cnt_s[i] = '0;
            kill_cnt_s    = kill_cnt_s + 4'd1;
          end else begin
            if (hit[i]) begin
              health_s[i] = health_r[i] - 3'd1;
            end else begin
              health_s[i] = health_r[i];
            end
            if (frame_tick) begin
              y_sum_s = {1'b0, y_r[i]} + 11'(FALL_STEP);
              if (y_sum_s >= 11'(Y_LIMIT)) begin
                state_s[i] = ST_IDLE;
                escape_s   = 1'b1;
              end else begin
                y_s[i] = y_sum_s[9:0];
              end
            end else begin
              y_s[i] = y_r[i];
            end
          end
        end
        ST_BOOM: begin
          if (game_en && frame_tick) begin
            if (boom_cnt_r[i] == BW'(BOOM_FRAMES - 1)) begin
              state_s[i] = ST_IDLE;
            end else begin
              boom_cnt_s[i] = boom_cnt_r[i] + BW'(1);
            end
          end else begin
            state_s[i] = ST_BOOM;
          end
        end
        default: begin
          state_s[i] = ST_IDLE;
        end
      endcase
    end
    kills_sum_s = {1'b0, kills_r} + {5'd0, kill_cnt_s};
    if (kills_sum_s > 9'd255) begin
      kills_s = 8'd255;
    end else begin
      kills_s = kills_sum_s[7:0];
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        state_r[i]    <= ST_IDLE;
        x_r[i]        <= 10'd0;
        y_r[i]        <= 10'd0;
        health_r[i]   <= 3'd0;
        boom_cnt_r[i] <= '0;
      end
      spawn_cnt_r    <= '0;
      lfsr_r         <= LFSR_SEED;
      kills_r        <= 8'd0;
      slot_en_r      <= '0;
      slot_boom_r    <= '0;
      spawn_pulse_r  <= 1'b0;
      escape_pulse_r <= 1'b0;
    end else begin
      for (int i = 0; i < N_SLOTS; i++) begin
        state_r[i]     <= state_s[i];
        x_r[i]         <= x_s[i];
        y_r[i]         <= y_s[i];
        health_r[i]    <= health_s[i];
        boom_cnt_r[i]  <= boom_cnt_s[i];
        slot_en_r[i]   <= (state_s[i] == ST_ACTIVE);
        slot_boom_r[i] <= (state_s[i] == ST_BOOM);
      end
      spawn_cnt_r    <= spawn_cnt_s;
      lfsr_r         <= lfsr_s;
      kills_r        <= kills_s;
      spawn_pulse_r  <= spawn_try_s && spawn_found_s;
      escape_pulse_r <= escape_s;
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_pack
    assign slot_x[10*g +: 10]     = x_r[g];
    assign slot_y[10*g +: 10]     = y_r[g];
    assign slot_health[3*g +: 3]  = health_r[g];
  end

  assign slot_en      = slot_en_r;
  assign slot_boom    = slot_boom_r;
  assign spawn_pulse  = spawn_pulse_r;
  assign escape_pulse = escape_pulse_r;
  assign kills        = kills_r;

endmodule

// File: tb/tb_enemy_wave_ctrl.sv
// Bench for enemy_wave_ctrl: two instances (default and fast spawn) checked every
// cycle against a slot-record model, plus hand-computed scenario checks.
module tb_enemy_wave_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        game_en = 1'b0;
  logic [3:0]  hit = 4'd0;

  logic [3:0]  d_en, d_boom, f_en, f_boom;
  logic [39:0] d_x, d_y, f_x, f_y;
  logic [11:0] d_h, f_h;
  logic        d_sp, d_esc, f_sp, f_esc;
  logic [7:0]  d_kills, f_kills;

  int n_cmp = 0;
  int n_bad = 0;

  // model: per instance, per slot status 0=idle 1=active 2=boom
  int ms [2][4];
  int mx [2][4];
  int my [2][4];
  int mh [2][4];
  int mb [2][4];
  int mcnt [2];
  int mlfsr [2];
  int mkills [2];
  int msp [2];
  int mesc [2];

  always #5 clk = ~clk;

  enemy_wave_ctrl u_dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_en(game_en), .hit(hit),
    .slot_en(d_en), .slot_boom(d_boom), .slot_x(d_x), .slot_y(d_y),
    .slot_health(d_h), .spawn_pulse(d_sp), .escape_pulse(d_esc), .kills(d_kills)
  );

  enemy_wave_ctrl #(.SPAWN_FRAMES(20)) u_fast (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_en(game_en), .hit(hit),
    .slot_en(f_en), .slot_boom(f_boom), .slot_x(f_x), .slot_y(f_y),
    .slot_health(f_h), .spawn_pulse(f_sp), .escape_pulse(f_esc), .kills(f_kills)
  );

  function automatic int spawn_period(input int k);
    return (k == 0) ? 90 : 20;
  endfunction

  function automatic void model_reset(input int k);
    for (int i = 0; i < 4; i++) begin
      ms[k][i] = 0; mx[k][i] = 0; my[k][i] = 0; mh[k][i] = 0; mb[k][i] = 0;
    end
    mcnt[k] = 0; mlfsr[k] = 'h2A5; mkills[k] = 0; msp[k] = 0; mesc[k] = 0;
  endfunction

  function automatic void model_step(input int k, input bit ft, input bit ge, input logic [3:0] h);
    int target = -1;
    int new_kills = 0;
    int esc = 0;
    int lf = mlfsr[k];
    mlfsr[k] = ((lf << 1) & 1022) | (((lf >> 9) ^ (lf >> 6)) & 1);
    if (ge && ft) begin
      if (mcnt[k] == spawn_period(k) - 1) begin
        mcnt[k] = 0;
        for (int i = 3; i >= 0; i--) if (ms[k][i] == 0) target = i;
      end else begin
        mcnt[k] = mcnt[k] + 1;
      end
    end
    if (ge) begin
      for (int i = 0; i < 4; i++) begin
        if (ms[k][i] == 1) begin
          if (h[i] && mh[k][i] == 1) begin
            mh[k][i] = 0; ms[k][i] = 2; mb[k][i] = 0; new_kills++;
          end else begin
            if (h[i]) mh[k][i] = mh[k][i] - 1;
            if (ft) begin
              if (my[k][i] + 2 >= 480) begin ms[k][i] = 0; esc = 1; end
              else my[k][i] = my[k][i] + 2;
            end
          end
        end else if (ms[k][i] == 2 && ft) begin
          if (mb[k][i] == 15) ms[k][i] = 0;
          else mb[k][i] = mb[k][i] + 1;
        end
      end
    end
    msp[k] = 0;
    if (target >= 0) begin
      ms[k][target] = 1; my[k][target] = 0; mh[k][target] = 3;
      mx[k][target] = (lf <= 590) ? lf : lf - 591;
      msp[k] = 1;
    end
    mesc[k] = esc;
    mkills[k] = (mkills[k] + new_kills > 255) ? 255 : mkills[k] + new_kills;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_inst(input int k, input logic [3:0] en, input logic [3:0] boom,
                          input logic [39:0] x, input logic [39:0] y, input logic [11:0] h,
                          input logic sp, input logic esc, input logic [7:0] kl);
    logic [3:0]  e_en, e_boom;
    logic [39:0] e_x, e_y;
    logic [11:0] e_h;
    string p;
    p = (k == 0) ? "d" : "f";
    for (int i = 0; i < 4; i++) begin
      e_en[i]        = (ms[k][i] == 1);
      e_boom[i]      = (ms[k][i] == 2);
      e_x[10*i +: 10] = 10'(mx[k][i]);
      e_y[10*i +: 10] = 10'(my[k][i]);
      e_h[3*i +: 3]   = 3'(mh[k][i]);
    end
    chk({p, "_slot_en"}, 64'(en), 64'(e_en));
    chk({p, "_slot_boom"}, 64'(boom), 64'(e_boom));
    chk({p, "_slot_x"}, 64'(x), 64'(e_x));
    chk({p, "_slot_y"}, 64'(y), 64'(e_y));
    chk({p, "_slot_health"}, 64'(h), 64'(e_h));
    chk({p, "_spawn_pulse"}, 64'(sp), 64'(msp[k]));
    chk({p, "_escape_pulse"}, 64'(esc), 64'(mesc[k]));
    chk({p, "_kills"}, 64'(kl), 64'(mkills[k]));
  endtask

  task automatic cyc(input logic ft, input logic [3:0] h);
    frame_tick = ft;
    hit = h;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) model_reset(k);
      else model_step(k, ft, game_en, h);
    end
    #1;
    chk_inst(0, d_en, d_boom, d_x, d_y, d_h, d_sp, d_esc, d_kills);
    chk_inst(1, f_en, f_boom, f_x, f_y, f_h, f_sp, f_esc, f_kills);
    frame_tick = 1'b0;
    hit = 4'd0;
  endtask

  task automatic frame(input logic [3:0] h);
    cyc(1'b1, h);
    cyc(1'b0, 4'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 4'd0);
    cyc(1'b0, 4'd0);
    rst = 1'b0;
  endtask

  initial begin
    int seen;
    int n;
    int got;
    model_reset(0);
    model_reset(1);

    // reset state
    do_reset();
    chk("rst_en", 64'(d_en), 64'd0);
    chk("rst_x", 64'(d_x), 64'd0);
    chk("rst_kills", 64'(d_kills), 64'd0);

    // first spawn exactly on the 90th frame
    game_en = 1'b1;
    seen = 0;
    for (int i = 0; i < 89; i++) begin
      cyc(1'b1, 4'd0);
      if (d_sp) seen++;
      cyc(1'b0, 4'd0);
    end
    chk("no_early_spawn", 64'(seen), 64'd0);
    cyc(1'b1, 4'd0);
    chk("spawn90_pulse", 64'(d_sp), 64'd1);
    chk("spawn90_en", 64'(d_en), 64'd1);
    chk("spawn90_y", 64'(d_y[9:0]), 64'd0);
    chk("spawn90_health", 64'(d_h[2:0]), 64'd3);
    chk("spawn90_x_range", 64'(d_x[9:0] <= 10'd590), 64'd1);
    cyc(1'b0, 4'd0);

    // three hits kill slot 0, then a 16-frame explosion
    cyc(1'b0, 4'b0001);
    chk("hit1_health", 64'(d_h[2:0]), 64'd2);
    cyc(1'b0, 4'b0001);
    chk("hit2_health", 64'(d_h[2:0]), 64'd1);
    cyc(1'b0, 4'b0001);
    chk("hit3_health", 64'(d_h[2:0]), 64'd0);
    chk("hit3_boom", 64'(d_boom[0]), 64'd1);
    chk("hit3_kills", 64'(d_kills), 64'd1);
    for (int i = 0; i < 15; i++) frame(4'd0);
    chk("boom15_still", 64'(d_boom[0]), 64'd1);
    frame(4'd0);
    chk("boom16_done", 64'({d_boom[0], d_en[0]}), 64'd0);

    // next spawn, then escape after 240 frames
    got = 0;
    for (int i = 0; i < 100 && got == 0; i++) begin
      cyc(1'b1, 4'd0);
      if (d_sp) got = 1;
      cyc(1'b0, 4'd0);
    end
    chk("respawn_seen", 64'(got), 64'd1);
    n = 0;
    got = 0;
    while (got == 0 && n < 300) begin
      cyc(1'b1, 4'd0);
      n++;
      if (d_esc) got = 1;
      cyc(1'b0, 4'd0);
    end
    chk("escape_frames", 64'(n), 64'd240);
    chk("escape_idle", 64'(d_en[0]), 64'd0);
    chk("escape_kills", 64'(d_kills), 64'd1);

    // all slots full on the fast instance, then refill of slot 2
    do_reset();
    game_en = 1'b1;
    for (int i = 0; i < 80; i++) frame(4'd0);
    chk("full_en", 64'(f_en), 64'hF);
    for (int i = 0; i < 19; i++) frame(4'd0);
    cyc(1'b1, 4'd0);
    chk("full_no_spawn", 64'(f_sp), 64'd0);
    cyc(1'b0, 4'd0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 4'b0100);
    chk("slot2_boom", 64'(f_boom), 64'h4);
    for (int i = 0; i < 16; i++) frame(4'd0);
    chk("slot2_freed", 64'(f_en), 64'hB);
    for (int i = 0; i < 3; i++) frame(4'd0);
    cyc(1'b1, 4'd0);
    chk("refill_pulse", 64'(f_sp), 64'd1);
    chk("refill_en", 64'(f_en), 64'hF);
    chk("refill_y2", 64'(f_y[29:20]), 64'd0);
    chk("refill_h2", 64'(f_h[8:6]), 64'd3);
    chk("slot0_y_t120", 64'(f_y[9:0]), 64'd200);
    chk("slot1_y_t120", 64'(f_y[19:10]), 64'd160);
    cyc(1'b0, 4'd0);

    // killing hit vs non-killing hit in the same frame_tick cycle
    cyc(1'b0, 4'b0001);
    cyc(1'b0, 4'b0001);
    cyc(1'b1, 4'b0011);
    chk("kill_tick_boom", 64'(f_boom[0]), 64'd1);
    chk("kill_tick_y_held", 64'(f_y[9:0]), 64'd200);
    chk("hit_tick_health", 64'(f_h[5:3]), 64'd2);
    chk("hit_tick_y_moved", 64'(f_y[19:10]), 64'd162);
    chk("kill_tick_kills", 64'(f_kills), 64'd2);
    cyc(1'b0, 4'd0);

    // freeze for 200 frames
    game_en = 1'b0;
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      cyc(1'b1, (i == 50) ? 4'b0010 : 4'd0);
      if (f_sp || d_sp) seen++;
      cyc(1'b0, 4'd0);
    end
    chk("freeze_no_spawn", 64'(seen), 64'd0);
    chk("freeze_y1", 64'(f_y[19:10]), 64'd162);
    chk("freeze_h1", 64'(f_h[5:3]), 64'd2);
    chk("freeze_en", 64'(f_en), 64'hE);
    chk("freeze_boom", 64'(f_boom), 64'h1);
    game_en = 1'b1;
    for (int i = 0; i < 3; i++) frame(4'd0);
    chk("thaw_boom", 64'(f_boom[0]), 64'd1);
    chk("thaw_y1", 64'(f_y[19:10]), 64'd168);

    // asynchronous reset mid-explosion
    #2 rst = 1'b1;
    #1;
    chk("async_rst_f", 64'({f_en, f_boom, f_sp, f_esc, f_kills}), 64'd0);
    chk("async_rst_f_xyh", 64'({f_x, f_y, f_h}), 64'd0);
    chk("async_rst_d", 64'({d_en, d_boom, d_sp, d_esc, d_kills}), 64'd0);
    cyc(1'b0, 4'd0);
    rst = 1'b0;

    // randomized play
    game_en = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 199) == 0) game_en = ~game_en;
      rst = ($urandom_range(0, 7999) == 0);
      cyc(($urandom_range(0, 2) == 0), ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd0);
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
